sync_fifo_param: RTL and testbench
==================================

// Module: sync_fifo_param
// PURPOSE
//  Parametrised single-clock FIFO; successor to the fixed 8x16 FIFO block.
//  Configurable width/depth, same-cycle read+write, almost-full/empty flags, occupancy count, overflow/underflow pulses.
//  Sits between producer/consumer blocks in one clock domain; drop-in for the old FIFO at WIDTH=8, DEPTH=16.
// PARAMETERS
//  WIDTH      8   data word width in bits (>=1)
//  DEPTH      16  number of entries; power of two, >=2
//  AF_MARGIN  2   almost_full asserts when count >= DEPTH-AF_MARGIN (0..DEPTH-1)
//  AE_MARGIN  2   almost_empty asserts when count <= AE_MARGIN (0..DEPTH-1)
// PORTS
//  clk           in   1              rising-edge clock; the only clock
//  rst_n         in   1              reset, synchronous, active-low
//  wr            in   1              write request
//  din           in   WIDTH          write data
//  rd            in   1              read request
//  dout          out  WIDTH          read data
//  full          out  1              count == DEPTH
//  empty         out  1              count == 0
//  almost_full   out  1              count >= DEPTH-AF_MARGIN
//  almost_empty  out  1              count <= AE_MARGIN
//  count         out  $clog2(DEPTH+1) current occupancy
//  overflow      out  1              1-cycle pulse: write rejected
//  underflow     out  1              1-cycle pulse: read rejected
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): wptr=rptr=0, count=0, dout=0, overflow=underflow=0; mem not cleared.
//    Reset overrides all requests in that cycle; in-flight data is discarded.
//  - rd_acc = rd & !empty.  wr_acc = wr & (!full | rd_acc)  (write on full allowed only with same-cycle read).
//  - wr_acc: mem[wptr]<=din, wptr<=wptr+1 (wraps DEPTH-1 -> 0).
//  - rd_acc: rptr<=rptr+1 (wraps). count <= count + wr_acc - rd_acc; never exceeds DEPTH, never below 0.
//  - Empty with wr&rd: write accepted, read rejected (underflow=1), count+1.
//  - Full with wr&rd: both accepted, count stays DEPTH, read returns oldest word, not din.
//  - overflow <= wr & !wr_acc; underflow <= rd & !rd_acc; registered, one cycle after request.
//  - full/empty/almost_*/count are combinational from the count register; update the cycle after the accepted op.
//  - Standard mode: dout <= mem[rptr] on rd_acc; 1-cycle read latency; dout holds otherwise.
//  - No FSM beyond the pointer/count state; all state updates on posedge clk only.
// CONFIGURATION
//  SYNC_FIFO_FWFT_EN defined: first-word-fall-through. dout = mem[rptr] combinationally whenever !empty
//    (0-cycle latency); rd acts as pop/acknowledge; dout is don't-care while empty; dout reset term dropped.
//  Undefined: standard mode above (registered dout, 1-cycle latency).
//  Flag, count, pointer and overflow/underflow behaviour identical in both modes.
// STRUCTURE
//  Package fifo_pkg: function clog2-based width helpers, localparam types ptr_t/cnt_t derivation,
//    shared default constants (FIFO_DEF_WIDTH=8, FIFO_DEF_DEPTH=16).
//  Sub-module fifo_mem: simple dual-port RAM (1 sync write port, 1 async read port), WIDTH x DEPTH;
//    sync_fifo_param holds pointers, count, flags, dout register.
// TESTING  (WIDTH=8, DEPTH=16, AF_MARGIN=2, AE_MARGIN=2)
//  1. Reset, write 0x01..0x10 -> full=1 after 16th, count=16; read 16 -> dout 0x01..0x10 in order, empty=1.
//  2. Full, wr=1 din=0xAA, rd=0 -> overflow pulse 1 cycle, count=16, 0xAA never read out.
//  3. Empty, rd=1 -> underflow pulse, dout unchanged; empty, wr&rd din=0x55 -> count=1, underflow=1.
//  4. Full, wr&rd din=0x77 -> count stays 16, dout=oldest; drain -> 0x77 emerges last.
//  5. Wrap: 40 interleaved writes/reads with count 0..16 -> scoreboard match, pointers wrap cleanly;
//     almost_full at count 14, almost_empty at count <=2.
//  6. rst_n=0 mid-stream with count=9 -> next cycle count=0, empty=1, dout=0, flags cleared;
//     FWFT build: first write shows din on dout the cycle after the write with no rd.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared width helpers and default constants for the parametrised synchronous FIFO.
package fifo_pkg;

    localparam int FIFO_DEF_WIDTH = 8;
    localparam int FIFO_DEF_DEPTH = 16;
    localparam int FIFO_DEF_AF    = 2;
    localparam int FIFO_DEF_AE    = 2;

    // Pointer width; a depth of 1 still needs one address bit to keep vectors legal.
    function automatic int fifo_addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy must represent 0..DEPTH inclusive.
    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Even parity over a word, available to wrappers that protect the data path.
    function automatic logic fifo_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/fifo_chk.sv
// Structural invariants of the FIFO occupancy state, kept apart from the datapath.
module fifo_chk #(
    parameter int DEPTH = 16,
    parameter int CW    = 5
) (
    input logic          clk,
    input logic          rst_n,
    input logic [CW-1:0] count,
    input logic          full,
    input logic          empty
);

    // Occupancy never exceeds the storage size.
    a_count_range: assert property (@(posedge clk) disable iff (!rst_n)
        count <= CW'(DEPTH));

    // Full and empty are mutually exclusive for any legal depth.
    a_full_empty: assert property (@(posedge clk) disable iff (!rst_n)
        !(full && empty));

endmodule

// File: rtl/fifo_mem.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
module fifo_mem
    import fifo_pkg::*;
#(
    parameter int WIDTH = FIFO_DEF_WIDTH,
    parameter int DEPTH = FIFO_DEF_DEPTH,
    parameter int AW    = fifo_addr_w(FIFO_DEF_DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_r [DEPTH];

    // Storage is intentionally not reset; stale words are never exposed past the count.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy flags and overflow/underflow pulses.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through output; default is registered dout.
module sync_fifo_param
    import fifo_pkg::*;
#(
    parameter int WIDTH     = FIFO_DEF_WIDTH,
    parameter int DEPTH     = FIFO_DEF_DEPTH,
    parameter int AF_MARGIN = FIFO_DEF_AF,
    parameter int AE_MARGIN = FIFO_DEF_AE
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       wr,
    input  logic [WIDTH-1:0]           din,
    input  logic                       rd,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = fifo_addr_w(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);

    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [AW-1:0] PTR_ZERO = AW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] AF_LVL   = CW'(DEPTH - AF_MARGIN);
    localparam logic [CW-1:0] AE_LVL   = CW'(AE_MARGIN);

    logic [AW-1:0]    wptr_r;
    logic [AW-1:0]    rptr_r;
    logic [CW-1:0]    count_r;
    logic             overflow_r;
    logic             underflow_r;

    logic             full_s;
    logic             empty_s;
    logic             almost_full_s;
    logic             almost_empty_s;
    logic             rd_acc_s;
    logic             wr_acc_s;
    logic [CW-1:0]    count_nxt_s;
    logic [WIDTH-1:0] rdata_s;

    // Status flags decode directly from the occupancy register.
    always_comb begin
        full_s         = (count_r == CNT_FULL);
        empty_s        = (count_r == CNT_ZERO);
        almost_full_s  = (count_r >= AF_LVL);
        almost_empty_s = (count_r <= AE_LVL);
    end

    // A write into a full FIFO is only legal when a read frees a slot in the same cycle.
    always_comb begin
        rd_acc_s = rd & ~empty_s;
        wr_acc_s = wr & (~full_s | rd_acc_s);
    end

    // Next occupancy; simultaneous accept of both ops leaves it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_nxt_s = count_r + CNT_ONE;
            2'b01:   count_nxt_s = count_r - CNT_ONE;
            default: count_nxt_s = count_r;
        endcase
    end

    // Pointer, occupancy and error-pulse state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r      <= PTR_ZERO;
            rptr_r      <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            overflow_r  <= 1'b0;
            underflow_r <= 1'b0;
        end else begin
            if (wr_acc_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end else begin
                wptr_r <= wptr_r;
            end
            if (rd_acc_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end else begin
                rptr_r <= rptr_r;
            end
            count_r     <= count_nxt_s;
            overflow_r  <= wr & ~wr_acc_s;
            underflow_r <= rd & ~rd_acc_s;
        end
    end

    // Read port sees the pre-edge contents, so a full-FIFO read+write returns the oldest word.
    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (wr_acc_s),
        .waddr (wptr_r),
        .wdata (din),
        .raddr (rptr_r),
        .rdata (rdata_s)
    );

`ifdef SYNC_FIFO_FWFT_EN
    assign dout = rdata_s;
`else
    logic [WIDTH-1:0] dout_r;

    // Registered read data: updates only on an accepted read, holds otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_r <= {WIDTH{1'b0}};
        end else if (rd_acc_s) begin
            dout_r <= rdata_s;
        end else begin
            dout_r <= dout_r;
        end
    end

    assign dout = dout_r;
`endif

    assign full         = full_s;
    assign empty        = empty_s;
    assign almost_full  = almost_full_s;
    assign almost_empty = almost_empty_s;
    assign count        = count_r;
    assign overflow     = overflow_r;
    assign underflow    = underflow_r;

    fifo_chk #(
        .DEPTH (DEPTH),
        .CW    (CW)
    ) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .count (count_r),
        .full  (full_s),
        .empty (empty_s)
    );

endmodule

// File: tb/tb_sync_fifo_param.sv
// Directed scoreboard bench for sync_fifo_param at WIDTH=8, DEPTH=16, margins 2/2.
// Honours SYNC_FIFO_FWFT_EN the same way the design does.
module tb_sync_fifo_param;

    localparam int W  = 8;
    localparam int D  = 16;
    localparam int AF = 2;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         wr;
    logic [W-1:0] din;
    logic         rd;
    logic [W-1:0] dout;
    logic         full;
    logic         empty;
    logic         almost_full;
    logic         almost_empty;
    logic [4:0]   count;
    logic         overflow;
    logic         underflow;

    int           vectors = 0;
    int           errs    = 0;
    logic [W-1:0] sb_q[$];
    int           m_count = 0;
    logic [W-1:0] m_dout  = 8'h00;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH     (W),
        .DEPTH     (D),
        .AF_MARGIN (AF),
        .AE_MARGIN (AE)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr           (wr),
        .din          (din),
        .rd           (rd),
        .dout         (dout),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_flags(input string tag);
        chk({tag, "_count"}, 32'(count), 32'(m_count));
        chk({tag, "_full"}, 32'(full), 32'(m_count == D));
        chk({tag, "_empty"}, 32'(empty), 32'(m_count == 0));
        chk({tag, "_afull"}, 32'(almost_full), 32'(m_count >= D - AF));
        chk({tag, "_aempty"}, 32'(almost_empty), 32'(m_count <= AE));
    endtask

    // One clock of stimulus; the model decides acceptance from its own occupancy.
    task automatic step(input string tag, input logic w, input logic [W-1:0] d, input logic r);
        bit           racc;
        bit           wacc;
        logic [W-1:0] exp_rd;
        exp_rd = 8'h00;
        @(negedge clk);
        wr  = w;
        din = d;
        rd  = r;
        racc = r && (m_count > 0);
        wacc = w && ((m_count < D) || racc);
`ifdef SYNC_FIFO_FWFT_EN
        #1;
        if (m_count > 0) chk({tag, "_fwft_dout"}, 32'(dout), 32'(sb_q[0]));
`endif
        if (racc) exp_rd = sb_q.pop_front();
        if (wacc) sb_q.push_back(d);
        m_count = m_count + int'(wacc) - int'(racc);
        @(posedge clk);
        #1;
`ifndef SYNC_FIFO_FWFT_EN
        if (racc) m_dout = exp_rd;
        chk({tag, "_dout"}, 32'(dout), 32'(m_dout));
`endif
        chk({tag, "_ovf"}, 32'(overflow), 32'(w && !wacc));
        chk({tag, "_udf"}, 32'(underflow), 32'(r && !racc));
        chk_flags(tag);
    endtask

    // Reset with requests asserted to show reset overrides them.
    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        wr    = 1'b1;
        rd    = 1'b1;
        din   = 8'hEE;
        @(posedge clk);
        #1;
        sb_q.delete();
        m_count = 0;
        m_dout  = 8'h00;
`ifndef SYNC_FIFO_FWFT_EN
        chk({tag, "_dout"}, 32'(dout), 32'h0);
`endif
        chk({tag, "_ovf"}, 32'(overflow), 32'h0);
        chk({tag, "_udf"}, 32'(underflow), 32'h0);
        chk_flags(tag);
        @(negedge clk);
        rst_n = 1'b1;
        wr    = 1'b0;
        rd    = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout vectors=%0d", vectors);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        wr    = 1'b0;
        rd    = 1'b0;
        din   = 8'h00;
        do_reset("reset");

        // Fill, overflow attempt, drain in order.
        for (int i = 1; i <= 16; i++) step("t1_fill", 1'b1, 8'(i), 1'b0);
        chk("t1_full_after16", 32'(full), 32'h1);
        step("t2_ovf", 1'b1, 8'hAA, 1'b0);
        step("t2_after", 1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 16; i++) step("t1_drain", 1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t1_last_word", 32'(dout), 32'h10);
`endif
        chk("t1_empty", 32'(empty), 32'h1);

        // Underflow on empty, then write+read on empty.
        step("t3_udf", 1'b0, 8'h00, 1'b1);
        step("t3_wr_rd_empty", 1'b1, 8'h55, 1'b1);
        step("t3_read55", 1'b0, 8'h00, 1'b1);

        // Write+read while full keeps count and returns the oldest word.
        for (int i = 0; i < 16; i++) step("t4_fill", 1'b1, 8'(8'h20 + i), 1'b0);
        step("t4_full_wr_rd", 1'b1, 8'h77, 1'b1);
        for (int i = 0; i < 16; i++) step("t4_drain", 1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
        chk("t4_last_is_77", 32'(dout), 32'h77);
`endif

        // Interleaved traffic sweeping occupancy up then down across pointer wrap.
        for (int i = 0; i < 80; i++) begin
            logic w;
            logic r;
            if (i < 40) begin
                w = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) == 0);
            end else begin
                w = ($urandom_range(0, 3) == 0);
                r = ($urandom_range(0, 3) != 0);
            end
            step("t5_mix", w, 8'($urandom_range(0, 255)), r);
        end
        while (m_count > 0) step("t5_drain", 1'b0, 8'h00, 1'b1);

        // Reset mid-stream at occupancy 9.
        for (int i = 0; i < 9; i++) step("t6_fill", 1'b1, 8'(8'h90 + i), 1'b0);
        chk("t6_count9", 32'(count), 32'd9);
        do_reset("t6_reset");
        step("t6_post_wr", 1'b1, 8'h3C, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
        chk("t6_fwft_fall", 32'(dout), 32'h3C);
`endif
        step("t6_post_rd", 1'b0, 8'h00, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
